ctr_seek_ctrl: RTL and testbench

CTR_SEEK_CTRL -- requirements
Module: ctr_seek_ctrl

---
 rtl/ctr_pkg.sv | 22 ++
 rtl/cmp_mag.sv | 20 ++
 rtl/ctr_seek_ctrl.sv | 146 ++++++++++++++
 tb/tb_ctr_seek_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// ---------------------------------------------------------------------------
// ctr_pkg
// Shared constants and the seek FSM state encoding for the seek controller
// and the up/down counter it drives.
//   W   : width of the count, target and step counter
//   MAX : highest legal count value
// ---------------------------------------------------------------------------
package ctr_pkg;

    localparam int W   = 5;
    localparam int MAX = 20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMP    = 3'd1,
        STEP   = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/cmp_mag.sv
// ---------------------------------------------------------------------------
// cmp_mag
// W-bit unsigned magnitude comparator.
//   i_a, i_b : operands (unsigned)
//   o_eq     : i_a == i_b
//   o_gt     : i_a >  i_b
// ---------------------------------------------------------------------------
module cmp_mag #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_eq,
    output logic         o_gt
);

    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/ctr_seek_ctrl.sv
// ---------------------------------------------------------------------------
// ctr_seek_ctrl
// Drives an external up/down counter one step at a time until its output
// matches a requested target. Each step is CMP -> STEP -> SETTLE so the
// counter's register latency is absorbed before the next compare.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : seek request, sampled in IDLE only
//   target : requested count, captured with start
//   cur    : registered output of the counter
//   ct     : counter direction (0 = increment, 1 = decrement)
//   cn     : counter enable, one cycle per step
//   busy   : seek in progress (CMP, STEP, SETTLE)
//   done   : one-cycle pulse when cur reached the target
//   err    : one-cycle pulse on illegal target or on timeout
//   steps  : cn pulses issued in the current or last seek
// All outputs are registered (Moore); each is written together with the
// state it belongs to.
// ---------------------------------------------------------------------------
module ctr_seek_ctrl #(
    parameter int W   = ctr_pkg::W,
    parameter int MAX = ctr_pkg::MAX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] target,
    input  logic [W-1:0] cur,
    output logic         ct,
    output logic         cn,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] steps
);

    import ctr_pkg::*;

    localparam logic [W-1:0] MAX_W     = W'(MAX);
    localparam logic [W-1:0] TIMEOUT_W = W'(MAX + 1);

    state_t       r_state;
    logic [W-1:0] r_tgt_q;
    logic         r_dir;

    logic w_cur_eq;
    logic w_cur_gt;
    logic w_max_eq;
    logic w_max_gt;
    logic w_tgt_legal;
    logic w_steps_max;

    // Compare of the counter against the latched target.
    cmp_mag #(.W(W)) u_cmp_cur (
        .i_a  (cur),
        .i_b  (r_tgt_q),
        .o_eq (w_cur_eq),
        .o_gt (w_cur_gt)
    );

    // Same comparator reused with MAX on the left: target <= MAX is legal.
    cmp_mag #(.W(W)) u_cmp_lim (
        .i_a  (MAX_W),
        .i_b  (target),
        .o_eq (w_max_eq),
        .o_gt (w_max_gt)
    );

    assign w_tgt_legal = w_max_eq | w_max_gt;
    assign w_steps_max = (steps == TIMEOUT_W);

    // r_dir is only non-zero during STEP, so it can drive ct straight from
    // the flop and ct reads 0 in every other state.
    assign ct = r_dir;

    // NOTE: sequential state uses non-blocking assignments only; the pulse
    // outputs are defaulted to 0 each cycle so they last exactly one state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_tgt_q <= '0;
            r_dir   <= 1'b0;
            cn      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            steps   <= '0;
        end else begin
            cn    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            r_dir <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_tgt_legal) begin
                            r_tgt_q <= target;
                            steps   <= '0;
                            busy    <= 1'b1;
                            r_state <= CMP;
                        end else begin
                            err     <= 1'b1;
                            r_state <= ERR;
                        end
                    end
                end

                CMP: begin
                    if (w_cur_eq) begin
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else if (w_steps_max) begin
                        // Counter is not following the enables.
                        err     <= 1'b1;
                        r_state <= ERR;
                    end else begin
                        r_dir   <= w_cur_gt;
                        cn      <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= STEP;
                    end
                end

                STEP: begin
                    if (!w_steps_max) begin
                        steps <= steps + 1'b1;
                    end
                    busy    <= 1'b1;
                    r_state <= SETTLE;
                end

                SETTLE: begin
                    busy    <= 1'b1;
                    r_state <= CMP;
                end

                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_seek_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ctr_seek_ctrl
// Scoreboard bench for ctr_seek_ctrl driving a real up/down counter.
// Stimulus pushes the hand-computed outcome of each seek into a queue; a
// monitor on the falling edge pops and compares whenever done or err fires,
// and checks ct on every cn pulse.
// ---------------------------------------------------------------------------
module tb_ctr_seek_ctrl;

    import ctr_pkg::*;

    typedef struct {
        bit is_err;
        int cycle;
        int steps;
        int cur;
        int pulses;
        bit ct;
        bit busy_seen;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] cur;
    logic         ct, cn, busy, done, err;
    logic [W-1:0] steps;

    // Counter controls
    logic         cn_link = 1'b1;
    logic         cnt_load = 1'b0;
    logic [W-1:0] cnt_val = '0;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t q[$];
    bit   abort_mode = 1'b0;
    int   pulses     = 0;
    bit   busy_seen  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ctr_seek_ctrl #(.W(W), .MAX(MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .cur    (cur),
        .ct     (ct),
        .cn     (cn),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .steps  (steps)
    );

    // Up/down counter; cn_link=0 models a disconnected enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur <= '0;
        else if (cnt_load)
            cur <= cnt_val;
        else if (cn && cn_link)
            cur <= ct ? cur - 1'b1 : cur + 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            pulses    = 0;
            busy_seen = 1'b0;
        end else begin
            if (busy) busy_seen = 1'b1;
            if (cn) begin
                pulses++;
                if (!abort_mode && q.size() > 0)
                    check("ct_on_cn", int'(ct), int'(q[0].ct));
            end
            if (done || err) begin
                if (abort_mode || q.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                    check("unexpected_err", int'(err), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("event_is_err", int'(err), int'(e.is_err));
                    check("event_is_done", int'(done), int'(!e.is_err));
                    check("event_cycle", cyc, e.cycle);
                    check("steps", int'(steps), e.steps);
                    check("cur", int'(cur), e.cur);
                    check("cn_pulses", pulses, e.pulses);
                    check("busy_seen", int'(busy_seen), int'(e.busy_seen));
                end
                pulses    = 0;
                busy_seen = 1'b0;
            end
        end
    end

    // Load the counter; returns on a falling edge.
    task automatic preload(input int v);
        @(negedge clk);
        cnt_load = 1'b1;
        cnt_val  = W'(v);
        @(negedge clk);
        cnt_load = 1'b0;
    endtask

    // Issue a seek at the current falling edge and wait for its outcome.
    task automatic seek(input int tgt, input bit is_err, input int lat,
                        input int exp_steps, input int exp_cur,
                        input int exp_pulses, input bit exp_ct,
                        input bit exp_busy);
        exp_t e;
        e.is_err    = is_err;
        e.cycle     = cyc + lat;
        e.steps     = exp_steps;
        e.cur       = exp_cur;
        e.pulses    = exp_pulses;
        e.ct        = exp_ct;
        e.busy_seen = exp_busy;
        q.push_back(e);
        start  = 1'b1;
        target = W'(tgt);
        @(negedge clk);
        start  = 1'b0;
        target = W'(31);   // must not be resampled mid-seek
        for (int i = 0; i < 200; i++) begin
            #1;
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("seek_timeout", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int n_cn;
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_cn", int'(cn), 0);
        check("rst_ct", int'(ct), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_steps", int'(steps), 0);
        rst = 1'b0;

        // 0 -> 2: two up steps, done at N+8
        preload(0);
        seek(2, 1'b0, 8, 2, 2, 2, 1'b0, 1'b1);

        // 20 -> 17: three down steps, done at N+11
        preload(20);
        seek(17, 1'b0, 11, 3, 17, 3, 1'b1, 1'b1);

        // 7 -> 7: no step, done at N+2
        preload(7);
        seek(7, 1'b0, 2, 0, 7, 0, 1'b0, 1'b1);

        // Illegal target 25: err at N+1, steps unchanged, busy never high
        @(negedge clk);
        seek(25, 1'b1, 1, 0, 7, 0, 1'b0, 1'b0);

        // Boundary: target == MAX is legal
        preload(19);
        seek(20, 1'b0, 5, 1, 20, 1, 1'b0, 1'b1);

        // Counter enable disconnected: 21 pulses then timeout err at N+65
        cn_link = 1'b0;
        preload(0);
        seek(5, 1'b1, 65, 21, 0, 21, 1'b0, 1'b1);
        cn_link = 1'b1;

        // Reset during the second STEP of a 0 -> 10 seek
        preload(0);
        abort_mode = 1'b1;
        start  = 1'b1;
        target = W'(10);
        @(negedge clk);
        start = 1'b0;
        n_cn = 0;
        for (int i = 0; i < 20; i++) begin
            if (cn) n_cn++;
            if (n_cn == 2) break;
            @(negedge clk);
        end
        check("abort_reached_step", n_cn, 2);
        check("abort_steps_before", int'(steps), 1);
        rst = 1'b1;
        #1;
        check("abort_cn", int'(cn), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_steps", int'(steps), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        abort_mode = 1'b0;
        // First start right after reset release: 0 -> 1
        seek(1, 1'b0, 5, 1, 1, 1, 1'b0, 1'b1);

        // Boundary: target == MAX+1 is illegal, steps hold at 1
        @(negedge clk);
        seek(21, 1'b1, 1, 1, 1, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
